// File: rtl/rst_sequencer_pkg.sv
// rst_seq_pkg
// Shared types and constants for the reset sequencer block.
//   rst_seq_state_t : sequencer FSM states (ASSERT, RELEASE, RUN)
//   rst_cause_t     : 2-bit encoding of the cause of the last reset
//   RST_COUNT_W     : width of the saturating reset-event counter
//   cnt_width()     : counter width able to hold 0..limit-1, at least 1 bit

package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_t;

    typedef logic [1:0] rst_cause_t;

    localparam rst_cause_t RST_CAUSE_POR = 2'd0;
    localparam rst_cause_t RST_CAUSE_EXT = 2'd1;
    localparam rst_cause_t RST_CAUSE_SW  = 2'd2;

    localparam int RST_COUNT_W = 8;

    // A limit of 1 still needs one bit so that the counter signal exists.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/rst_sequencer_sync_cell.sv
// rst_sync_cell
// Multi-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk     in  : clock
//   reset_n in  : synchronous active-low reset; all flops load RESET_VALUE
//   d       in  : asynchronous input level
//   q       out : synchronized level, SYNC_STAGES cycles behind d

module rst_sync_cell #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; bit 0 is the metastability-exposed flop, the last bit is
    // the only one the rest of the design may look at.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
// Merges the board reset, an asynchronous external reset request and a
// software reset pulse into staged, synchronous active-low resets. All stages
// are held for a stretch period after the last request clears and then
// released one at a time, in index order, STAGE_GAP cycles apart.
// Ports:
//   clk           in  : clock
//   reset_n       in  : synchronous active-low reset
//   ext_rst_req_n in  : asynchronous active-low external reset request (level)
//   sw_rst_req    in  : single-cycle software reset request
//   stage_reset_n out : per-stage active-low resets (registered)
//   rst_done      out : all stages released (registered)
//   rst_cause     out : cause of last reset, POR/EXT/SW (registered)
//   rst_count     out : saturating count of EXT and SW events (registered)

module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ext_rst_req_n,
    input  logic                   sw_rst_req,
    output logic [NUM_STAGES-1:0]  stage_reset_n,
    output logic                   rst_done,
    output rst_cause_t             rst_cause,
    output logic [RST_COUNT_W-1:0] rst_count
);

    localparam int STRETCH_W = cnt_width(STRETCH_CYCLES);
    localparam int GAP_W     = cnt_width(STAGE_GAP);
    localparam int IDX_W     = cnt_width(NUM_STAGES);

    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST     = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_STAGES - 1);

    rst_seq_state_t         state_q, state_d;
    logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]       stage_idx_q, stage_idx_d;
    logic [NUM_STAGES-1:0]  stage_reset_n_q, stage_reset_n_d;
    logic                   rst_done_q, rst_done_d;
    rst_cause_t             rst_cause_q, rst_cause_d;
    logic [RST_COUNT_W-1:0] rst_count_q, rst_count_d;
    logic                   ext_req_q;

    logic ext_sync_n;
    logic ext_req;
    logic req;
    logic rst_event;

    rst_sync_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_ext_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ext_rst_req_n),
        .q       (ext_sync_n)
    );

    assign ext_req = ~ext_sync_n;
    assign req     = ext_req | sw_rst_req;

    // A held external level must count as one event, so only its rising edge
    // is an event; every software pulse cycle is an event of its own.
    assign rst_event = (ext_req & ~ext_req_q) | sw_rst_req;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ASSERT;
            stretch_cnt_q   <= '0;
            gap_cnt_q       <= '0;
            stage_idx_q     <= '0;
            stage_reset_n_q <= '0;
            rst_done_q      <= 1'b0;
            rst_cause_q     <= RST_CAUSE_POR;
            rst_count_q     <= '0;
            ext_req_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            stretch_cnt_q   <= stretch_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            stage_idx_q     <= stage_idx_d;
            stage_reset_n_q <= stage_reset_n_d;
            rst_done_q      <= rst_done_d;
            rst_cause_q     <= rst_cause_d;
            rst_count_q     <= rst_count_d;
            ext_req_q       <= ext_req;
        end
    end

    // Sequencer next state. A request overrides everything, including a
    // release or RUN transition scheduled for the same cycle. Stages are a
    // thermometer code, so releasing the next stage shifts a 1 in at bit 0.
    always_comb begin
        state_d         = state_q;
        stretch_cnt_d   = stretch_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        stage_idx_d     = stage_idx_q;
        stage_reset_n_d = stage_reset_n_q;
        rst_done_d      = rst_done_q;

        if (req) begin
            state_d         = ASSERT;
            stretch_cnt_d   = '0;
            gap_cnt_d       = '0;
            stage_idx_d     = '0;
            stage_reset_n_d = '0;
            rst_done_d      = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    stage_reset_n_d = '0;
                    rst_done_d      = 1'b0;
                    if (stretch_cnt_q == STRETCH_LAST) begin
                        state_d         = RELEASE;
                        stretch_cnt_d   = '0;
                        gap_cnt_d       = '0;
                        stage_idx_d     = '0;
                        stage_reset_n_d = NUM_STAGES'(1);
                    end else begin
                        stretch_cnt_d = stretch_cnt_q + STRETCH_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        if (stage_idx_q == IDX_LAST) begin
                            state_d    = RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            stage_idx_d     = stage_idx_q + IDX_W'(1);
                            stage_reset_n_d = (stage_reset_n_q << 1) | NUM_STAGES'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    stage_reset_n_d = '1;
                    rst_done_d      = 1'b1;
                end
                default: begin
                    state_d         = ASSERT;
                    stretch_cnt_d   = '0;
                    gap_cnt_d       = '0;
                    stage_idx_d     = '0;
                    stage_reset_n_d = '0;
                    rst_done_d      = 1'b0;
                end
            endcase
        end
    end

    // Cause and event bookkeeping. EXT wins whenever the synced external
    // request is active at the event; the counter sticks at all-ones.
    always_comb begin
        rst_cause_d = rst_cause_q;
        rst_count_d = rst_count_q;
        if (rst_event) begin
            rst_cause_d = ext_req ? RST_CAUSE_EXT : RST_CAUSE_SW;
            if (rst_count_q != '1) begin
                rst_count_d = rst_count_q + RST_COUNT_W'(1);
            end
        end
    end

    assign stage_reset_n = stage_reset_n_q;
    assign rst_done      = rst_done_q;
    assign rst_cause     = rst_cause_q;
    assign rst_count     = rst_count_q;

endmodule
